// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_TX_SEND
    } state_t;

    localparam logic [7:0] CMD_WR_DEF = 8'hAA;
    localparam logic [7:0] CMD_RD_DEF = 8'hBB;
    localparam int         CNT_W      = 8;

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the rx_valid level into a one-cycle byte strobe and samples the byte
// and its error flags on the 0->1 transition.
module uart_byte_strobe #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_parity_err,
    input  logic                  rx_stop_err,
    output logic                  byte_stb,
    output logic [DATA_WIDTH-1:0] byte_data,
    output logic                  byte_perr,
    output logic                  byte_serr
);

    logic valid_q;
    logic rise;

    assign rise = rx_valid & ~valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            byte_stb  <= 1'b0;
            byte_data <= '0;
            byte_perr <= 1'b0;
            byte_serr <= 1'b0;
        end else begin
            valid_q  <= rx_valid;
            byte_stb <= rise;
            if (rise) begin
                byte_data <= rx_data;
                byte_perr <= rx_parity_err;
                byte_serr <= rx_stop_err;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame sequencer: received bytes -> register-file writes/reads, read data -> tx.
// Build option: define RX_ERR_DROP_EN to abort frames on bytes with rx errors.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(CMD_WR_DEF),
    parameter logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(CMD_RD_DEF),
    parameter int                    RD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_parity_err,
    input  logic                  rx_stop_err,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic                  rf_wr_en,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  rf_rd_en,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic                  frame_err,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                state, state_d;
    logic                  byte_stb, byte_perr, byte_serr, drop;
    logic [DATA_WIDTH-1:0] byte_data;
    logic [CNT_W-1:0]      cnt;
    logic                  timeout;
    logic                  wr_d, rd_d, tx_d, err_d;
    logic                  addr_ld, wdata_ld, tx_ld, cnt_clr;

    uart_byte_strobe #(.DATA_WIDTH(DATA_WIDTH)) u_strobe (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_stop_err   (rx_stop_err),
        .byte_stb      (byte_stb),
        .byte_data     (byte_data),
        .byte_perr     (byte_perr),
        .byte_serr     (byte_serr)
    );

`ifdef RX_ERR_DROP_EN
    assign drop = byte_stb & (byte_perr | byte_serr);
`else
    logic unused_err;
    assign unused_err = byte_perr ^ byte_serr;
    assign drop       = 1'b0;
`endif

    assign timeout = (cnt >= TO_LAST);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (byte_stb && byte_data == CMD_WR)      state_d = S_WR_ADDR;
                else if (byte_stb && byte_data == CMD_RD) state_d = S_RD_ADDR;
            end
            S_WR_ADDR: if (byte_stb) state_d = S_WR_DATA;
            S_WR_DATA: if (byte_stb) state_d = S_IDLE;
            S_RD_ADDR: if (byte_stb) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rf_rd_valid)  state_d = S_TX_SEND;
                else if (timeout) state_d = S_IDLE;
            end
            S_TX_SEND: if (!tx_busy) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (drop) state_d = S_IDLE;
    end

    always_comb begin
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        tx_d     = 1'b0;
        err_d    = 1'b0;
        addr_ld  = 1'b0;
        wdata_ld = 1'b0;
        tx_ld    = 1'b0;
        cnt_clr  = 1'b0;
        case (state)
            S_IDLE:    err_d = byte_stb && byte_data != CMD_WR && byte_data != CMD_RD;
            S_WR_ADDR: addr_ld = byte_stb;
            S_WR_DATA: begin
                wdata_ld = byte_stb;
                wr_d     = byte_stb;
            end
            S_RD_ADDR: begin
                addr_ld = byte_stb;
                rd_d    = byte_stb;
                cnt_clr = byte_stb;
            end
            S_RD_WAIT: begin
                tx_ld = rf_rd_valid;
                err_d = byte_stb || (!rf_rd_valid && timeout);
            end
            S_TX_SEND: begin
                tx_d  = !tx_busy;
                err_d = byte_stb;
            end
            default: ;
        endcase
        // A bad byte kills the whole frame, including any strobe it would have caused.
        if (drop) begin
            err_d    = 1'b1;
            wr_d     = 1'b0;
            rd_d     = 1'b0;
            tx_d     = 1'b0;
            addr_ld  = 1'b0;
            wdata_ld = 1'b0;
            tx_ld    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (state == S_RD_WAIT && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // frame_err is suppressed right after a pulse so it never runs two cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_addr    <= '0;
            rf_wr_data <= '0;
            tx_data    <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            tx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rf_wr_en  <= wr_d;
            rf_rd_en  <= rd_d;
            tx_valid  <= tx_d;
            frame_err <= err_d & ~frame_err;
            if (addr_ld)  rf_addr    <= byte_data[ADDR_WIDTH-1:0];
            if (wdata_ld) rf_wr_data <= byte_data;
            if (tx_ld)    tx_data    <= rf_rd_data;
        end
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer placed after the UART receive datapath. It turns the stream of received bytes into register-file transactions: write frames carry command, address and data, and read frames carry command and address. Read results are handed to the UART transmit side. It also detects malformed frames and reports them on a single error strobe.

## Interface
Parameters:
- DATA_WIDTH, 8, width of received bytes, register data and tx data
- ADDR_WIDTH, 4, register-file address width; the address is taken from the low ADDR_WIDTH bits of the address byte
- CMD_WR, 8'hAA, write-frame command code
- CMD_RD, 8'hBB, read-frame command code
- RD_TIMEOUT, 15, maximum cycles to wait for rf_rd_valid (1..255)

Ports (reset: rst, asynchronous, active-low; clock: clk):
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rx_data  in  DATA_WIDTH  received byte from the UART receiver
- rx_valid  in  1  byte-valid level; may stay high for several cycles per byte
- rx_parity_err  in  1  parity error for the current byte
- rx_stop_err  in  1  stop error for the current byte
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_en  out  1  one-cycle write strobe
- rf_wr_data  out  DATA_WIDTH  write data
- rf_rd_en  out  1  one-cycle read strobe
- rf_rd_data  in  DATA_WIDTH  read data
- rf_rd_valid  in  1  read data valid (single cycle)
- tx_data  out  DATA_WIDTH  byte to transmit
- tx_valid  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- frame_err  out  1  one-cycle error strobe
- busy  out  1  high whenever the state is not IDLE

## Operation
- **Byte strobe.**
  - rx_valid is registered.
  - A byte is accepted only on a 0->1 transition of rx_valid.
  - rx_data, rx_parity_err and rx_stop_err are sampled in that same cycle.
  - A level held high never produces a second byte.
- **States.** IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- **IDLE.**
  - CMD_WR -> WR_ADDR.
  - CMD_RD -> RD_ADDR.
  - Any other byte: discarded, frame_err pulse, remain in IDLE.
- **WR_ADDR.** Latch the address into rf_addr -> WR_DATA.
- **WR_DATA.** Latch the byte into rf_wr_data, pulse rf_wr_en -> IDLE.
- **RD_ADDR.** Latch the address, pulse rf_rd_en -> RD_WAIT, and clear the timeout counter.
- **RD_WAIT.**
  - On rf_rd_valid: capture rf_rd_data into tx_data -> TX_SEND.
  - Otherwise the counter increments every cycle. When the count reaches RD_TIMEOUT: frame_err pulse -> IDLE.
  - rf_rd_valid in the same cycle as the timeout has priority (the read completes).
- **TX_SEND.** When tx_busy == 0, pulse tx_valid with tx_data stable -> IDLE. While tx_busy == 1, wait indefinitely.
- **Bytes arriving in RD_WAIT or TX_SEND.** Discarded, frame_err pulse, state unchanged.
- **Output hold.** rf_addr, rf_wr_data and tx_data hold their last value until overwritten.
- **Reset mid-frame.** Returns immediately to IDLE with all outputs at their reset values. No partial write is ever issued.

## Timing
- **Reset values.** All outputs 0, state IDLE, edge register 0.
- **Byte acceptance.** rising edge of rx_valid seen at clock edge N -> state update and latches at edge N+1.
- **Write.** rf_wr_en is high for exactly the one cycle after the data byte is accepted. rf_addr and rf_wr_data are valid in that same cycle.
- **Read.** rf_rd_en is high for exactly one cycle after the address byte is accepted, with rf_addr valid.
- **Transmit.** Minimum latency from rf_rd_valid to tx_valid is 2 cycles (capture, then TX_SEND with tx_busy low).
- **Strobes.** frame_err, rf_wr_en, rf_rd_en and tx_valid are never high for more than one consecutive cycle.
- **Counter width.** The timeout counter is 8 bits and saturates. No wrap-around is permitted.

## Configuration
- **RX_ERR_DROP_EN defined.**
  - An accepted byte with rx_parity_err or rx_stop_err set aborts the frame, whatever the state: frame_err pulse -> IDLE.
  - No rf_wr_en or rf_rd_en is issued for that frame.
- **RX_ERR_DROP_EN undefined.**
  - The error inputs are ignored.
  - Bytes are used as received.

## Structure
- **Shared package uart_cmd_pkg.** Holds the state enum, the default command codes CMD_WR and CMD_RD, and the timeout-counter width constant.
- **Sub-module uart_byte_strobe.** Contains the rx_valid edge detector and the sampling registers for rx_data and the error flags. It outputs a one-cycle byte_stb with the sampled byte and flags.

## Test plan
- **Write frame.** Bytes AA, 05, 3C, each with rx_valid held high 8 cycles -> exactly one rf_wr_en pulse with rf_addr=5 and rf_wr_data=3C; busy low afterwards.
- **Read frame.** Bytes BB, 0A; rf_rd_valid with rf_rd_data=5A three cycles after rf_rd_en; tx_busy=0 -> single tx_valid with tx_data=5A.
- **Back-pressure.** Same read, but tx_busy high for 20 cycles -> tx_valid is asserted only in the cycle after tx_busy falls.
- **Timeout.** Bytes BB, 03 with no rf_rd_valid -> frame_err pulse 15 cycles after RD_WAIT is entered, then IDLE; a following AA/01/FF frame writes normally.
- **Bad command and error byte.** Byte 42 -> frame_err and no state change. With RX_ERR_DROP_EN: AA, then 05 with rx_parity_err=1 -> frame_err and no rf_wr_en. Without the macro: AA, 05 (parity error), 11 -> write of 11 to address 5.
- **Reset mid-frame.** Bytes AA, 05, then rst low for 2 cycles -> all outputs 0 and no rf_wr_en, even when byte 3C follows.
